// File: rtl/ps2_keyboard_decoder_pkg.sv
// ps2_keyboard_decoder_pkg: shared PS/2 prefixes, Hack special keycodes, receiver states
package ps2_keyboard_decoder_pkg;
  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BREAK = 8'hF0;
  localparam logic [7:0] PS2_SC_LSHIFT = 8'h12;
  localparam logic [7:0] PS2_SC_RSHIFT = 8'h59;
  localparam logic [7:0] HACK_KEY_NEWLINE = 8'd128;
  localparam logic [7:0] HACK_KEY_BACKSPACE = 8'd129;
  localparam logic [7:0] HACK_KEY_LEFT = 8'd130;
  localparam logic [7:0] HACK_KEY_UP = 8'd131;
  localparam logic [7:0] HACK_KEY_RIGHT = 8'd132;
  localparam logic [7:0] HACK_KEY_DOWN = 8'd133;
  localparam logic [7:0] HACK_KEY_HOME = 8'd134;
  localparam logic [7:0] HACK_KEY_END = 8'd135;
  localparam logic [7:0] HACK_KEY_PGUP = 8'd136;
  localparam logic [7:0] HACK_KEY_PGDN = 8'd137;
  localparam logic [7:0] HACK_KEY_INSERT = 8'd138;
  localparam logic [7:0] HACK_KEY_DELETE = 8'd139;
  localparam logic [7:0] HACK_KEY_ESC = 8'd140;
  localparam logic [7:0] HACK_KEY_F1 = 8'd141;
  localparam logic [7:0] HACK_KEY_F2 = 8'd142;
  localparam logic [7:0] HACK_KEY_F3 = 8'd143;
  localparam logic [7:0] HACK_KEY_F4 = 8'd144;
  localparam logic [7:0] HACK_KEY_F5 = 8'd145;
  localparam logic [7:0] HACK_KEY_F6 = 8'd146;
  localparam logic [7:0] HACK_KEY_F7 = 8'd147;
  localparam logic [7:0] HACK_KEY_F8 = 8'd148;
  localparam logic [7:0] HACK_KEY_F9 = 8'd149;
  localparam logic [7:0] HACK_KEY_F10 = 8'd150;
  localparam logic [7:0] HACK_KEY_F11 = 8'd151;
  localparam logic [7:0] HACK_KEY_F12 = 8'd152;
  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} rx_state_e;
  function automatic logic frame_ok(input logic [7:0] data, input logic parity, input logic stop);
    return (^{data, parity}) & stop;
  endfunction
endpackage

// File: rtl/ps2_keyboard_decoder_scancode_to_hack.sv
// ps2_keyboard_decoder_scancode_to_hack: combinational Set-2 scancode to Hack keycode table
module ps2_keyboard_decoder_scancode_to_hack
  import ps2_keyboard_decoder_pkg::*;
(
  input  logic       ext_i,
  input  logic       shift_i,
  input  logic [7:0] scancode_i,
  output logic [7:0] hack_code_o
);
  logic [15:0] pair;
  // Each entry holds {unshifted, shifted} so shift just selects a byte
  always_comb begin
    pair = '0;
    case ({ext_i, scancode_i})
      9'h01C: pair = "aA";
      9'h032: pair = "bB";
      9'h021: pair = "cC";
      9'h023: pair = "dD";
      9'h024: pair = "eE";
      9'h02B: pair = "fF";
      9'h034: pair = "gG";
      9'h033: pair = "hH";
      9'h043: pair = "iI";
      9'h03B: pair = "jJ";
      9'h042: pair = "kK";
      9'h04B: pair = "lL";
      9'h03A: pair = "mM";
      9'h031: pair = "nN";
      9'h044: pair = "oO";
      9'h04D: pair = "pP";
      9'h015: pair = "qQ";
      9'h02D: pair = "rR";
      9'h01B: pair = "sS";
      9'h02C: pair = "tT";
      9'h03C: pair = "uU";
      9'h02A: pair = "vV";
      9'h01D: pair = "wW";
      9'h022: pair = "xX";
      9'h035: pair = "yY";
      9'h01A: pair = "zZ";
      9'h016: pair = "1!";
      9'h01E: pair = "2@";
      9'h026: pair = "3#";
      9'h025: pair = "4$";
      9'h02E: pair = "5%";
      9'h036: pair = "6^";
      9'h03D: pair = "7&";
      9'h03E: pair = "8*";
      9'h046: pair = "9(";
      9'h045: pair = "0)";
      9'h00E: pair = "`~";
      9'h04E: pair = "-_";
      9'h055: pair = "=+";
      9'h054: pair = "[{";
      9'h05B: pair = "]}";
      9'h05D: pair = "\\|";
      9'h04C: pair = ";:";
      9'h052: pair = "'\"";
      9'h041: pair = ",<";
      9'h049: pair = ".>";
      9'h04A: pair = "/?";
      9'h029: pair = "  ";
      9'h05A: pair = {2{HACK_KEY_NEWLINE}};
      9'h066: pair = {2{HACK_KEY_BACKSPACE}};
      9'h076: pair = {2{HACK_KEY_ESC}};
      9'h005: pair = {2{HACK_KEY_F1}};
      9'h006: pair = {2{HACK_KEY_F2}};
      9'h004: pair = {2{HACK_KEY_F3}};
      9'h00C: pair = {2{HACK_KEY_F4}};
      9'h003: pair = {2{HACK_KEY_F5}};
      9'h00B: pair = {2{HACK_KEY_F6}};
      9'h083: pair = {2{HACK_KEY_F7}};
      9'h00A: pair = {2{HACK_KEY_F8}};
      9'h001: pair = {2{HACK_KEY_F9}};
      9'h009: pair = {2{HACK_KEY_F10}};
      9'h078: pair = {2{HACK_KEY_F11}};
      9'h007: pair = {2{HACK_KEY_F12}};
      9'h16B: pair = {2{HACK_KEY_LEFT}};
      9'h175: pair = {2{HACK_KEY_UP}};
      9'h174: pair = {2{HACK_KEY_RIGHT}};
      9'h172: pair = {2{HACK_KEY_DOWN}};
      9'h16C: pair = {2{HACK_KEY_HOME}};
      9'h169: pair = {2{HACK_KEY_END}};
      9'h17D: pair = {2{HACK_KEY_PGUP}};
      9'h17A: pair = {2{HACK_KEY_PGDN}};
      9'h170: pair = {2{HACK_KEY_INSERT}};
      9'h171: pair = {2{HACK_KEY_DELETE}};
      default: pair = '0;
    endcase
  end
  assign hack_code_o = shift_i ? pair[7:0] : pair[15:8];
endmodule

// File: rtl/ps2_keyboard_decoder.sv
// ps2_keyboard_decoder: PS/2 Set-2 frame receiver and make/break decoder producing a Hack keycode
module ps2_keyboard_decoder
  import ps2_keyboard_decoder_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int TIMEOUT_WIDTH = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keycode,
  output logic       key_event,
  output logic       frame_error
);
  logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q;
  logic clk_prev_q;
  logic ps2_clk_s, ps2_dat_s, fall;
  rx_state_e state_q, state_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [7:0] sr_q, sr_d;
  logic par_q, par_d;
  logic [TIMEOUT_WIDTH-1:0] tmo_q, tmo_d;
  logic byte_ok, byte_bad, timeout;
  logic ext_q, ext_d, brk_q, brk_d, shift_q, shift_d;
  logic [8:0] held_q, held_d, code9;
  logic [7:0] keycode_q, keycode_d, xlat;
  logic key_event_q, key_event_d, frame_error_q, frame_error_d;

  assign ps2_clk_s = clk_sync_q[SYNC_STAGES-1];
  assign ps2_dat_s = dat_sync_q[SYNC_STAGES-1];
  assign fall = clk_prev_q & ~ps2_clk_s;
  assign code9 = {ext_q, sr_q};

  ps2_keyboard_decoder_scancode_to_hack u_xlat (
    .ext_i      (ext_q),
    .shift_i    (shift_q),
    .scancode_i (sr_q),
    .hack_code_o(xlat)
  );

  // Bring the asynchronous PS/2 lines into clk and remember the previous clock level
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_data};
      clk_prev_q <= ps2_clk_s;
    end
  end

  // Receiver and decoder state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      bitcnt_q <= '0;
      sr_q <= '0;
      par_q <= 1'b0;
      tmo_q <= '0;
      ext_q <= 1'b0;
      brk_q <= 1'b0;
      shift_q <= 1'b0;
      held_q <= '0;
      keycode_q <= '0;
      key_event_q <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bitcnt_q <= bitcnt_d;
      sr_q <= sr_d;
      par_q <= par_d;
      tmo_q <= tmo_d;
      ext_q <= ext_d;
      brk_q <= brk_d;
      shift_q <= shift_d;
      held_q <= held_d;
      keycode_q <= keycode_d;
      key_event_q <= key_event_d;
      frame_error_q <= frame_error_d;
    end
  end

  // Frame receiver: start, 8 data bits LSB first, odd parity, stop; aborts on a stalled clock
  always_comb begin
    state_d = state_q;
    bitcnt_d = bitcnt_q;
    sr_d = sr_q;
    par_d = par_q;
    byte_ok = 1'b0;
    byte_bad = 1'b0;
    timeout = 1'b0;
    tmo_d = (state_q == ST_IDLE || fall) ? '0 : tmo_q + TIMEOUT_WIDTH'(1);
    if (fall) begin
      case (state_q)
        ST_IDLE: begin
          state_d = ps2_dat_s ? ST_IDLE : ST_DATA;
          bitcnt_d = '0;
        end
        ST_DATA: begin
          sr_d = {ps2_dat_s, sr_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          state_d = (bitcnt_q == 3'd7) ? ST_PARITY : ST_DATA;
        end
        ST_PARITY: begin
          par_d = ps2_dat_s;
          state_d = ST_STOP;
        end
        default: begin
          state_d = ST_IDLE;
          byte_ok = frame_ok(sr_q, par_q, ps2_dat_s);
          byte_bad = ~byte_ok;
        end
      endcase
    end else if (state_q != ST_IDLE && tmo_q == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
      state_d = ST_IDLE;
      timeout = 1'b1;
      tmo_d = '0;
    end
  end

  // Decoder: prefixes set flags, the final byte of a sequence updates shift or the held key
  always_comb begin
    ext_d = ext_q;
    brk_d = brk_q;
    shift_d = shift_q;
    held_d = held_q;
    keycode_d = keycode_q;
    key_event_d = 1'b0;
    frame_error_d = byte_bad | timeout;
    if (byte_ok) begin
      if (sr_q == PS2_PREFIX_EXT) begin
        ext_d = 1'b1;
      end else if (sr_q == PS2_PREFIX_BREAK) begin
        brk_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
        if (code9 == {1'b0, PS2_SC_LSHIFT} || code9 == {1'b0, PS2_SC_RSHIFT}) begin
          shift_d = ~brk_q;
        end else if (!brk_q && xlat != 8'd0) begin
          keycode_d = xlat;
          held_d = code9;
          key_event_d = xlat != keycode_q;
        end else if (brk_q && code9 == held_q && keycode_q != 8'd0) begin
          keycode_d = '0;
          held_d = '0;
          key_event_d = 1'b1;
        end
      end
    end
  end

  assign keycode = keycode_q;
  assign key_event = key_event_q;
  assign frame_error = frame_error_q;
endmodule

// File: tb/tb_ps2_keyboard_decoder.sv
// tb_ps2_keyboard_decoder: table-driven frame checks plus latency, timeout and reset sequences
module tb_ps2_keyboard_decoder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  logic [7:0] keycode;
  logic key_event, frame_error;
  int checks = 0;
  int errors = 0;
  int ev_cnt = 0;
  int fe_cnt = 0;
  int both_cnt = 0;

  typedef struct {
    logic [7:0] b;
    logic pf;
    logic st;
    logic [7:0] kc;
    int ev;
    int fe;
  } vec_t;
  vec_t tv[$];

  ps2_keyboard_decoder dut (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .keycode    (keycode),
    .key_event  (key_event),
    .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset) begin
      ev_cnt += int'(key_event);
      fe_cnt += int'(frame_error);
      both_cnt += int'(key_event & frame_error);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic add(input logic [7:0] b, input logic [7:0] kc, input int ev,
                     input logic pf = 1'b0, input logic st = 1'b1, input int fe = 0);
    vec_t v;
    v.b = b;
    v.pf = pf;
    v.st = st;
    v.kc = kc;
    v.ev = ev;
    v.fe = fe;
    tv.push_back(v);
  endtask

  // One PS/2 bit; pat records key_event on the first four cycles after the clock falls
  task automatic send_bit(input logic v, output logic [3:0] pat);
    pat = '0;
    @(negedge clk);
    ps2_data = v;
    repeat (3) @(negedge clk);
    ps2_clk = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k < 4) pat = {pat[2:0], key_event};
    end
    ps2_clk = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic pf, input logic st, output logic [3:0] pat);
    logic [10:0] f;
    f = {st, (~^b) ^ pf, b, 1'b0};
    for (int i = 0; i < 11; i++) send_bit(f[i], pat);
    ps2_data = 1'b1;
  endtask

  initial begin
    logic [3:0] pat;
    int ev0, fe0;
    add(8'h1C, 8'h61, 1);
    add(8'hF0, 8'h61, 0);
    add(8'h1C, 8'h00, 1);
    add(8'h12, 8'h00, 0);
    add(8'h1C, 8'h41, 1);
    add(8'hF0, 8'h41, 0);
    add(8'h1C, 8'h00, 1);
    add(8'hF0, 8'h00, 0);
    add(8'h12, 8'h00, 0);
    add(8'hE0, 8'h00, 0);
    add(8'h75, 8'd131, 1);
    add(8'hE0, 8'd131, 0);
    add(8'hF0, 8'd131, 0);
    add(8'h75, 8'h00, 1);
    add(8'h5A, 8'd128, 1);
    add(8'hF0, 8'd128, 0);
    add(8'h5A, 8'h00, 1);
    add(8'h76, 8'd140, 1);
    add(8'hF0, 8'd140, 0);
    add(8'h76, 8'h00, 1);
    add(8'h12, 8'h00, 0);
    add(8'h16, 8'h21, 1);
    add(8'hF0, 8'h21, 0);
    add(8'h16, 8'h00, 1);
    add(8'h4E, 8'h5F, 1);
    add(8'h12, 8'h5F, 0);
    add(8'hF0, 8'h5F, 0);
    add(8'h12, 8'h5F, 0);
    add(8'hF0, 8'h5F, 0);
    add(8'h4E, 8'h00, 1);
    add(8'h4E, 8'h2D, 1);
    add(8'hF0, 8'h2D, 0);
    add(8'h4E, 8'h00, 1);
    add(8'h05, 8'd141, 1);
    add(8'h07, 8'd152, 1);
    add(8'hF0, 8'd152, 0);
    add(8'h07, 8'h00, 1);
    add(8'hE0, 8'h00, 0);
    add(8'h6B, 8'd130, 1);
    add(8'hE0, 8'd130, 0);
    add(8'hF0, 8'd130, 0);
    add(8'h6B, 8'h00, 1);
    add(8'h1C, 8'h61, 1);
    add(8'hF0, 8'h61, 0);
    add(8'h23, 8'h61, 0);
    add(8'h1C, 8'h61, 0);
    add(8'h1C, 8'h61, 0);
    add(8'h1C, 8'h61, 0);
    add(8'hE0, 8'h61, 0);
    add(8'h5A, 8'h61, 0);
    add(8'h1C, 8'h61, 0, 1'b1, 1'b1, 1);
    add(8'h1C, 8'h61, 0, 1'b0, 1'b0, 1);
    add(8'hF0, 8'h61, 0);
    add(8'h1C, 8'h61, 0, 1'b1, 1'b1, 1);
    add(8'h1C, 8'h00, 1);

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_keycode", int'(keycode), 0);
    check("reset_key_event", int'(key_event), 0);
    check("reset_frame_error", int'(frame_error), 0);

    foreach (tv[i]) begin
      ev0 = ev_cnt;
      fe0 = fe_cnt;
      send_frame(tv[i].b, tv[i].pf, tv[i].st, pat);
      repeat (10) @(negedge clk);
      check($sformatf("vec%0d_keycode", i), int'(keycode), int'(tv[i].kc));
      check($sformatf("vec%0d_key_event", i), ev_cnt - ev0, tv[i].ev);
      check($sformatf("vec%0d_frame_error", i), fe_cnt - fe0, tv[i].fe);
    end

    send_frame(8'h1C, 1'b0, 1'b1, pat);
    check("make_latency_pattern", int'(pat), 4'b0010);
    check("make_latency_keycode", int'(keycode), 8'h61);
    send_frame(8'hF0, 1'b0, 1'b1, pat);
    send_frame(8'h1C, 1'b1, 1'b1, pat);
    repeat (3) @(negedge clk);
    check("error_latency_pattern", int'(pat), 4'b0000);
    send_frame(8'h1C, 1'b0, 1'b1, pat);
    check("break_latency_pattern", int'(pat), 4'b0010);
    check("break_keycode", int'(keycode), 0);

    ev0 = ev_cnt;
    fe0 = fe_cnt;
    send_bit(1'b0, pat);
    for (int i = 0; i < 4; i++) send_bit(1'b1, pat);
    repeat (49000) @(negedge clk);
    check("timeout_not_early", fe_cnt - fe0, 0);
    repeat (1500) @(negedge clk);
    check("timeout_error", fe_cnt - fe0, 1);
    check("timeout_no_event", ev_cnt - ev0, 0);
    ev0 = ev_cnt;
    send_frame(8'h1C, 1'b0, 1'b1, pat);
    repeat (10) @(negedge clk);
    check("after_timeout_keycode", int'(keycode), 8'h61);
    check("after_timeout_event", ev_cnt - ev0, 1);

    ev0 = ev_cnt;
    fe0 = fe_cnt;
    send_bit(1'b0, pat);
    for (int i = 0; i < 3; i++) send_bit(1'b0, pat);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    check("midreset_keycode", int'(keycode), 0);
    check("midreset_no_error", fe_cnt - fe0, 0);
    check("midreset_no_event", ev_cnt - ev0, 0);
    ev0 = ev_cnt;
    send_frame(8'h1C, 1'b0, 1'b1, pat);
    repeat (10) @(negedge clk);
    check("after_reset_keycode", int'(keycode), 8'h61);
    check("after_reset_event", ev_cnt - ev0, 1);
    check("after_reset_error", fe_cnt - fe0, 0);

    check("event_error_exclusive", both_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
